// File: rtl/duato_vc_port_alloc.sv
// Output-port allocator behind the torus Duato routing function: expands the destport
// code into candidate ports, picks one by credit count, and locks it for the packet.
module duato_vc_port_alloc #(
  parameter int CREDIT_MAX = 4,
  localparam int CW = $clog2(CREDIT_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flit_in_valid,
  input  logic          flit_in_head,
  input  logic          flit_in_tail,
  input  logic [3:0]    destport,
  output logic          flit_in_ready,
  input  logic [4:0]    credit_in,
  output logic [4:0]    flit_out_wr,
  output logic [4:0]    port_sel,
  output logic          credit_err,
  output logic [1:0]    state_dbg,
  output logic [5*CW-1:0] credit_dbg
);

  // Handshake: a flit moves on a cycle where flit_in_valid and flit_in_ready are both 1.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2} state_t;

  state_t        state, state_next;
  logic [4:0]    port_sel_next;
  logic [4:0]    mask_q, mask_next;
  logic [CW-1:0] credit [5];
  logic [4:0]    nonzero;
  logic [4:0]    cand, x_sel, y_sel, pick;
  logic [CW-1:0] cred_x, cred_y;
  logic          x_ok, y_ok, head_seen, tail_done;

  // Bit order LOCAL,EAST,NORTH,WEST,SOUTH; LOCAL only when neither a nor b is set.
  function automatic logic [4:0] decode(input logic [3:0] dp);
    logic [4:0] m;
    m = '0;
    if (!dp[1] && !dp[0]) begin
      m[0] = 1'b1;
    end else begin
      if (dp[1]) begin
        if (dp[3]) m[1] = 1'b1;
        else       m[3] = 1'b1;
      end
      if (dp[0]) begin
        if (dp[2]) m[4] = 1'b1;
        else       m[2] = 1'b1;
      end
    end
    return m;
  endfunction

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      nonzero[p] = (credit[p] != '0);
      credit_dbg[p*CW +: CW] = credit[p];
    end
  end

  // WAIT keeps the mask latched at head time; destport is not looked at again.
  always_comb begin
    cand   = (state == WAIT) ? mask_q : decode(destport);
    x_sel  = cand & 5'b01010;
    y_sel  = cand & 5'b10100;
    cred_x = cand[1] ? credit[1] : credit[3];
    cred_y = cand[4] ? credit[4] : credit[2];
    x_ok   = |(x_sel & nonzero);
    y_ok   = |(y_sel & nonzero);
    pick   = '0;
    if (cand[0]) begin
      pick = nonzero[0] ? 5'b00001 : 5'b00000;
    end else if (x_ok && (!y_ok || cred_x >= cred_y)) begin
      pick = x_sel;
    end else if (y_ok) begin
      pick = y_sel;
    end
  end

  assign head_seen = flit_in_valid && flit_in_head;
  assign tail_done = flit_in_valid && flit_in_ready && flit_in_tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      port_sel <= '0;
      mask_q   <= '0;
    end else begin
      state    <= state_next;
      port_sel <= port_sel_next;
      mask_q   <= mask_next;
    end
  end

  always_comb begin
    state_next    = state;
    port_sel_next = port_sel;
    mask_next     = mask_q;
    case (state)
      IDLE: begin
        if (head_seen) begin
          mask_next = cand;
          if (|pick) begin
            port_sel_next = pick;
            state_next    = ACTIVE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (|pick) begin
          port_sel_next = pick;
          state_next    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (tail_done) begin
          port_sel_next = '0;
          state_next    = IDLE;
        end
      end
      default: begin
        port_sel_next = '0;
        state_next    = IDLE;
      end
    endcase
  end

  always_comb begin
    flit_in_ready = (state == ACTIVE) && (|(port_sel & nonzero));
    flit_out_wr   = (flit_in_valid && flit_in_ready) ? port_sel : 5'b00000;
    state_dbg     = state;
  end

  // A write and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) credit[p] <= CW'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (credit_in[p] && !flit_out_wr[p]) begin
          if (credit[p] == CW'(CREDIT_MAX)) credit_err <= 1'b1;
          else                              credit[p] <= credit[p] + CW'(1);
        end else if (flit_out_wr[p] && !credit_in[p]) begin
          if (nonzero[p]) credit[p] <= credit[p] - CW'(1);
        end
        if (flit_out_wr[p] && !nonzero[p]) credit_err <= 1'b1;
      end
    end
  end

  a_no_write_without_credit: assert property (
    @(posedge clk) disable iff (reset) (flit_out_wr & ~nonzero) == 5'b00000
  );

endmodule

// File: tb/tb_duato_vc_port_alloc.sv
// Directed bench for duato_vc_port_alloc: per-cycle vector table plus a
// reset-mid-packet sequence.
module tb_duato_vc_port_alloc;

  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACT = 2'd2;
  localparam logic [4:0] L = 5'b00001, E = 5'b00010, N = 5'b00100, W = 5'b01000, S = 5'b10000;
  localparam logic [4:0] Z = 5'b00000;

  logic        clk, reset;
  logic        flit_in_valid, flit_in_head, flit_in_tail;
  logic [3:0]  destport;
  logic        flit_in_ready;
  logic [4:0]  credit_in, flit_out_wr, port_sel;
  logic        credit_err;
  logic [1:0]  state_dbg;
  logic [14:0] credit_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v, h, t;
    logic [3:0]  dp;
    logic [4:0]  cin;
    logic        rdy;
    logic [4:0]  wr, ps;
    logic [1:0]  st;
    logic        err;
    logic [14:0] cr;
  } vec_t;

  vec_t vecs[$];

  duato_vc_port_alloc #(.CREDIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .flit_in_valid(flit_in_valid), .flit_in_head(flit_in_head), .flit_in_tail(flit_in_tail),
    .destport(destport), .flit_in_ready(flit_in_ready), .credit_in(credit_in),
    .flit_out_wr(flit_out_wr), .port_sel(port_sel), .credit_err(credit_err),
    .state_dbg(state_dbg), .credit_dbg(credit_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] cr(int l, int e, int n, int w, int s);
    return {3'(s), 3'(w), 3'(n), 3'(e), 3'(l)};
  endfunction

  function automatic vec_t mk(logic v, logic h, logic t, logic [3:0] dp, logic [4:0] cin,
                              logic rdy, logic [4:0] wr, logic [4:0] ps, logic [1:0] st,
                              logic err, logic [14:0] c);
    vec_t r;
    r.v = v; r.h = h; r.t = t; r.dp = dp; r.cin = cin;
    r.rdy = rdy; r.wr = wr; r.ps = ps; r.st = st; r.err = err; r.cr = c;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic h, logic t, logic [3:0] dp, logic [4:0] cin);
    flit_in_valid = v; flit_in_head = h; flit_in_tail = t; destport = dp; credit_in = cin;
  endtask

  task automatic check_all(string tag, logic rdy, logic [4:0] wr, logic [4:0] ps,
                           logic [1:0] st, logic err, logic [14:0] c);
    chk({tag, ".ready"}, 32'(flit_in_ready), 32'(rdy));
    chk({tag, ".wr"},    32'(flit_out_wr),   32'(wr));
    chk({tag, ".sel"},   32'(port_sel),      32'(ps));
    chk({tag, ".state"}, 32'(state_dbg),     32'(st));
    chk({tag, ".err"},   32'(credit_err),    32'(err));
    chk({tag, ".credit"}, 32'(credit_dbg),   32'(c));
  endtask

  // Inputs are driven 1 time unit after the rising edge and outputs checked on the falling edge.
  task automatic apply(vec_t x, string tag);
    drive(x.v, x.h, x.t, x.dp, x.cin);
    @(negedge clk);
    check_all(tag, x.rdy, x.wr, x.ps, x.st, x.err, x.cr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, Z);

    // EAST 3-flit packet, EAST credit 4 -> 1
    vecs.push_back(mk(1,1,0,4'b1010,Z, 0,Z,Z,S_IDLE,0, cr(4,4,4,4,4)));
    vecs.push_back(mk(1,1,0,4'b1010,Z, 1,E,E,S_ACT, 0, cr(4,4,4,4,4)));
    vecs.push_back(mk(1,0,0,4'b1010,Z, 1,E,E,S_ACT, 0, cr(4,3,4,4,4)));
    vecs.push_back(mk(1,0,1,4'b1010,Z, 1,E,E,S_ACT, 0, cr(4,2,4,4,4)));
    // WEST 3-flit packet, WEST credit 4 -> 1
    vecs.push_back(mk(1,1,0,4'b0010,Z, 0,Z,Z,S_IDLE,0, cr(4,1,4,4,4)));
    vecs.push_back(mk(1,1,0,4'b0010,Z, 1,W,W,S_ACT, 0, cr(4,1,4,4,4)));
    vecs.push_back(mk(1,0,0,4'b0010,Z, 1,W,W,S_ACT, 0, cr(4,1,4,3,4)));
    vecs.push_back(mk(1,0,1,4'b0010,Z, 1,W,W,S_ACT, 0, cr(4,1,4,2,4)));
    // SOUTH 1-flit packet, SOUTH credit 4 -> 3
    vecs.push_back(mk(1,1,1,4'b0101,Z, 0,Z,Z,S_IDLE,0, cr(4,1,4,1,4)));
    vecs.push_back(mk(1,1,1,4'b0101,Z, 1,S,S,S_ACT, 0, cr(4,1,4,1,4)));
    // WEST=1 vs SOUTH=3 -> SOUTH
    vecs.push_back(mk(1,1,1,4'b0111,Z, 0,Z,Z,S_IDLE,0, cr(4,1,4,1,3)));
    vecs.push_back(mk(1,1,1,4'b0111,Z, 1,S,S,S_ACT, 0, cr(4,1,4,1,3)));
    // return a WEST credit, then WEST=2 vs SOUTH=2 -> WEST
    vecs.push_back(mk(0,0,0,4'b0000,W, 0,Z,Z,S_IDLE,0, cr(4,1,4,1,2)));
    vecs.push_back(mk(1,1,1,4'b0111,Z, 0,Z,Z,S_IDLE,0, cr(4,1,4,2,2)));
    vecs.push_back(mk(1,1,1,4'b0111,Z, 1,W,W,S_ACT, 0, cr(4,1,4,2,2)));
    // drain EAST to 0, next EAST head waits; destport changed to LOCAL while waiting
    vecs.push_back(mk(1,1,1,4'b1010,Z, 0,Z,Z,S_IDLE,0, cr(4,1,4,1,2)));
    vecs.push_back(mk(1,1,1,4'b1010,Z, 1,E,E,S_ACT, 0, cr(4,1,4,1,2)));
    vecs.push_back(mk(1,1,1,4'b1010,Z, 0,Z,Z,S_IDLE,0, cr(4,0,4,1,2)));
    vecs.push_back(mk(1,1,0,4'b0000,E, 0,Z,Z,S_WAIT,0, cr(4,0,4,1,2)));
    vecs.push_back(mk(1,1,0,4'b0000,Z, 0,Z,Z,S_WAIT,0, cr(4,1,4,1,2)));
    // EAST at 1 with credit returned alongside each write: no stall
    vecs.push_back(mk(1,1,0,4'b1010,E, 1,E,E,S_ACT, 0, cr(4,1,4,1,2)));
    vecs.push_back(mk(1,0,0,4'b1010,E, 1,E,E,S_ACT, 0, cr(4,1,4,1,2)));
    vecs.push_back(mk(1,0,1,4'b1010,Z, 1,E,E,S_ACT, 0, cr(4,1,4,1,2)));
    // NORTH credit at max -> saturates, sticky error
    vecs.push_back(mk(0,0,0,4'b0000,N, 0,Z,Z,S_IDLE,0, cr(4,0,4,1,2)));
    vecs.push_back(mk(0,0,0,4'b0000,Z, 0,Z,Z,S_IDLE,1, cr(4,0,4,1,2)));
    // WEST 2-flit packet with 1 credit: stall until credit returns
    vecs.push_back(mk(1,1,0,4'b0010,Z, 0,Z,Z,S_IDLE,1, cr(4,0,4,1,2)));
    vecs.push_back(mk(1,1,0,4'b0010,Z, 1,W,W,S_ACT, 1, cr(4,0,4,1,2)));
    vecs.push_back(mk(1,0,1,4'b0010,W, 0,Z,W,S_ACT, 1, cr(4,0,4,0,2)));
    vecs.push_back(mk(1,0,1,4'b0010,Z, 1,W,W,S_ACT, 1, cr(4,0,4,1,2)));
    vecs.push_back(mk(0,0,0,4'b0000,Z, 0,Z,Z,S_IDLE,1, cr(4,0,4,0,2)));

    @(negedge clk);
    check_all("reset", 1'b0, Z, Z, S_IDLE, 1'b0, cr(4,4,4,4,4));
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // LOCAL 4-flit packet, reset asserted during its second flit
    apply(mk(1,1,0,4'b0000,Z, 0,Z,Z,S_IDLE,1, cr(4,0,4,0,2)), "rst_head");
    apply(mk(1,1,0,4'b0000,Z, 1,L,L,S_ACT, 1, cr(4,0,4,0,2)), "rst_flit1");
    drive(1'b1, 1'b0, 1'b0, 4'b0000, Z);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check_all("rst_mid", 1'b0, Z, Z, S_IDLE, 1'b0, cr(4,4,4,4,4));
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(1,1,1,4'b0000,Z, 0,Z,Z,S_IDLE,0, cr(4,4,4,4,4)), "post_head");
    apply(mk(1,1,1,4'b0000,Z, 1,L,L,S_ACT, 0, cr(4,4,4,4,4)), "post_write");
    apply(mk(0,0,0,4'b0000,Z, 0,Z,Z,S_IDLE,0, cr(3,4,4,4,4)), "post_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duato_vc_port_alloc.md
Name: duato_vc_port_alloc

Overview:
- Sequential output-port allocator that sits directly downstream of the torus Duato routing function inside each router input port.
- Consumes the 4-bit {x,y,a,b} destport code and expands it to the candidate physical ports.
- Picks one candidate per packet using per-output credit counters, then holds that port until the tail flit passes.
- Drives a one-hot forward strobe towards the crossbar.

Parameters:
- CREDIT_MAX, 4, downstream buffer depth in flits per output port; credit counters reset to this value.
- CW, log2(CREDIT_MAX+1), credit counter width (derived localparam, not overridable).

Ports:
- clk  input  1  router clock
- reset  input  1  asynchronous, active-high reset
- flit_in_valid  input  1  input buffer presents a flit
- flit_in_head  input  1  presented flit is a head flit
- flit_in_tail  input  1  presented flit is a tail flit (head and tail may both be 1)
- destport  input  4  {x,y,a,b} from the routing function; valid only with a head flit
- flit_in_ready  output  1  flit consumed this cycle when flit_in_valid is also 1
- credit_in  input  5  one pulse per freed downstream slot; bit order LOCAL,EAST,NORTH,WEST,SOUTH = 0..4
- flit_out_wr  output  5  one-hot write strobe to the crossbar / output port
- port_sel  output  5  one-hot locked port for the current packet; 0 when idle
- credit_err  output  1  sticky flag: credit overflow or write with zero credit

Behaviour:
- Candidate decode, combinational:
  - a=1 → EAST if x=1, else WEST.
  - b=1 → SOUTH if y=1, else NORTH.
  - a=b=0 → LOCAL only; x and y are ignored.
- Credit counters, one per port, CW bits:
  - Reset to CREDIT_MAX.
  - Decrement on flit_out_wr[p].
  - Increment on credit_in[p].
  - Both in the same cycle → counter unchanged.
  - Increment at CREDIT_MAX → counter saturates and credit_err is set.
- FSM states IDLE, WAIT, ACTIVE. Reset values: state=IDLE, port_sel=0, flit_in_ready=0, flit_out_wr=0, credit_err=0.
- IDLE:
  - flit_in_ready=0.
  - On flit_in_valid&flit_in_head, evaluate candidates.
  - If any candidate has credit>0: choose the one with the larger credit count; on a tie prefer the X port (EAST/WEST); register it into port_sel and go to ACTIVE.
  - If no candidate has credit: go to WAIT and latch the candidate mask.
  - A non-head flit seen in IDLE is not consumed (ready stays 0).
- WAIT:
  - Each cycle, re-evaluate the latched candidates with the same rule.
  - When one has credit>0: load port_sel and go to ACTIVE.
  - destport is not re-sampled in WAIT.
- ACTIVE:
  - flit_in_ready = (credit[port_sel] > 0).
  - flit_out_wr = port_sel when flit_in_valid&flit_in_ready, else 0.
  - An accepted tail flit clears port_sel and returns to IDLE in the next cycle.
- Latency:
  - Head arrival to first write is 1 cycle when credit is available.
  - A 1-flit packet (head&tail) occupies exactly 2 cycles: IDLE, then ACTIVE.
- Credit returned in cycle N is usable for selection or ready in cycle N+1, because the counter is registered.
- Asserting reset mid-packet immediately returns the FSM to IDLE and reloads all counters to CREDIT_MAX; the partially sent packet is dropped.
- Back-to-back packets: a new head in the cycle after a tail is selected in IDLE, so there is a 1-cycle bubble per packet.
- credit_err is also set if flit_out_wr fires on a port with credit=0. This is impossible by design and checked by assertion.

Test Plan:
- Reset, then head with destport=4'b1010 (x=1,a=1), 3-flit packet → port_sel=00010 (EAST) in cycle 1; flit_out_wr=00010 for 3 cycles; EAST credit 4→1; back to IDLE.
- destport=4'b0111 (WEST/SOUTH) with credit WEST=1, SOUTH=3 → SOUTH chosen. Repeat with both at 2 → WEST chosen (X tie-break).
- Drain EAST to 0 credits, send head destport=4'b1010 → FSM in WAIT, ready=0; pulse credit_in[1] → EAST selected in the next cycle, and the head is written one cycle after that.
- In ACTIVE with EAST credit=1, set credit_in[1] in the same cycle as a write → counter stays 1, and the stream continues without stall.
- Pulse credit_in[2] while NORTH is at CREDIT_MAX=4 → counter stays 4 and credit_err=1 until reset.
- Assert reset during the second flit of a 4-flit LOCAL packet (destport=0000) → port_sel=0, state IDLE, all credits=4, credit_err=0; the next head is accepted normally.
